// File: rtl/btn_demux_router.sv
// Button-driven channel router.
// Two raw pushbuttons are synchronised and debounced. Their rising edges
// step a channel pointer forward or back. Each clock, SW is written into
// the LED channel that the pointer selects.
module btn_demux_router #(
    parameter int W         = 1,
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 4,
    parameter int MODE      = 0,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [W-1:0]        SW,
    input  logic [1:0]          BTN,
    output logic [N_CH*W-1:0]   LED,
    output logic [SEL_W-1:0]    SEL_OUT,
    output logic                CHG
);

    // The counter must be able to hold DB_CYCLES itself: the stable state
    // flips on the edge after the sample has differed for DB_CYCLES cycles.
    localparam int               CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       stable_p2;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       rise_p2;
    logic             step_fwd;
    logic             step_back;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [N_CH*W-1:0] led_q;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= BTN;
            sync_p1 <= sync_p0;
        end
    end

    // Per-button debounce: count consecutive differing samples, flip the
    // stable state when the count is reached, and flag 0->1 flips as a rise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable_p2 <= '0;
            rise_p2   <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                rise_p2[b] <= 1'b0;
                if (sync_p1[b] == stable_p2[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_MAX) begin
                    stable_p2[b] <= sync_p1[b];
                    rise_p2[b]   <= sync_p1[b];
                    db_cnt[b]    <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Next pointer: a lone rise steps with wrap; simultaneous rises cancel
    always_comb begin
        step_fwd  = rise_p2[0] & ~rise_p2[1];
        step_back = rise_p2[1] & ~rise_p2[0];
        ptr_next  = ptr;
        if (step_fwd) begin
            ptr_next = (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
        end else if (step_back) begin
            ptr_next = (ptr == '0) ? LAST_CH : ptr - SEL_W'(1);
        end
    end

    // Pointer register; CHG marks the cycle following a pointer move
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
            CHG <= 1'b0;
        end else begin
            ptr <= ptr_next;
            CHG <= step_fwd | step_back;
        end
    end

    // Route SW into the channel selected before this edge; in zero mode the
    // other channels are cleared, otherwise they keep their last value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ptr == SEL_W'(c)) begin
                    led_q[c*W +: W] <= SW;
                end else if (MODE == 1) begin
                    led_q[c*W +: W] <= '0;
                end
            end
        end
    end

    assign LED     = led_q;
    assign SEL_OUT = ptr;

endmodule

// File: tb/tb_btn_demux_router.sv
// Scoreboard bench for btn_demux_router: one hold-mode and one zero-mode
// instance share the same stimulus; expected states are queued by edge
// number and a monitor compares them on the falling clock edge.
module tb_btn_demux_router;

    logic       CLK;
    logic       RST;
    logic [0:0] SW;
    logic [1:0] BTN;
    logic [3:0] led0, led1;
    logic [1:0] sel0, sel1;
    logic       chg0, chg1;

    btn_demux_router #(.W(1), .N_CH(4), .DB_CYCLES(4), .MODE(0)) u_hold (
        .CLK(CLK), .RST(RST), .SW(SW), .BTN(BTN),
        .LED(led0), .SEL_OUT(sel0), .CHG(chg0)
    );

    btn_demux_router #(.W(1), .N_CH(4), .DB_CYCLES(4), .MODE(1)) u_zero (
        .CLK(CLK), .RST(RST), .SW(SW), .BTN(BTN),
        .LED(led1), .SEL_OUT(sel1), .CHG(chg1)
    );

    typedef struct {
        int at;
        int sel;
        int l0;
        int l1;
    } state_t;

    typedef struct {
        int at;
        int sel;
    } chg_t;

    state_t chk_q[$];
    chg_t   chg_q[$];
    int     edges  = 0;
    int     n_chk  = 0;
    int     n_pass = 0;
    int     mask   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) edges <= edges + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
    endfunction

    task automatic push_chk(input int at, input int sel, input int l0, input int l1);
        state_t s;
        s.at = at; s.sel = sel; s.l0 = l0; s.l1 = l1;
        chk_q.push_back(s);
    endtask

    // Expected trace for a step whose steady press was applied at negedge e
    task automatic expect_step(input int e, input int from, input int to);
        chg_t c;
        push_chk(e + 7, from, mask, 1 << from);
        push_chk(e + 8, to, mask, 1 << from);
        c.at = e + 8; c.sel = to;
        chg_q.push_back(c);
        mask = mask | (1 << to);
        push_chk(e + 9, to, mask, 1 << to);
    endtask

    task automatic press(input int b, input int hi, input int lo,
                         input int from, input int to, input bit step);
        int e;
        @(negedge CLK);
        e = edges;
        BTN[b] = 1'b1;
        if (step) expect_step(e, from, to);
        else push_chk(e + 9, from, mask, 1 << from);
        repeat (hi) @(negedge CLK);
        BTN[b] = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    // Monitor: timed state checks and CHG pulses
    always @(negedge CLK) begin
        bit exp_chg;
        while (chk_q.size() > 0 && chk_q[0].at <= edges) begin
            if (chk_q[0].at < edges) begin
                chk("stale_entry", chk_q[0].at, edges);
            end else begin
                chk("sel_hold", sel0, chk_q[0].sel);
                chk("sel_zero", sel1, chk_q[0].sel);
                chk("led_hold", led0, chk_q[0].l0);
                chk("led_zero", led1, chk_q[0].l1);
            end
            void'(chk_q.pop_front());
        end
        exp_chg = (chg_q.size() > 0 && chg_q[0].at == edges);
        if (chg0 || chg1 || exp_chg) begin
            chk("chg_hold", chg0, exp_chg);
            chk("chg_zero", chg1, exp_chg);
            if (exp_chg) begin
                chk("chg_sel", sel0, chg_q[0].sel);
                void'(chg_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e;
        int r;
        RST = 1'b1;
        BTN = 2'b00;
        SW  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_sel_hold", sel0, 0);
        chk("rst_sel_zero", sel1, 0);
        chk("rst_led_hold", led0, 0);
        chk("rst_led_zero", led1, 0);
        chk("rst_chg_hold", chg0, 0);
        chk("rst_chg_zero", chg1, 0);

        // Release and route SW into channel 0
        RST = 1'b0;
        SW  = 1'b1;
        r = edges;
        push_chk(r + 1, 0, 1, 1);
        @(negedge CLK);
        e = edges;
        SW = 1'b0;
        push_chk(e + 1, 0, 0, 0);
        @(negedge CLK);
        SW = 1'b1;
        push_chk(e + 2, 0, 1, 1);
        mask = 1;
        repeat (4) @(negedge CLK);

        // Four forward steps with wrap
        press(0, 10, 10, 0, 1, 1'b1);
        press(0, 10, 10, 1, 2, 1'b1);
        press(0, 10, 10, 2, 3, 1'b1);
        press(0, 10, 10, 3, 0, 1'b1);

        // Step back from 0 wraps to 3
        press(1, 10, 10, 0, 3, 1'b1);

        // Three-cycle glitch is ignored
        press(0, 3, 15, 3, 3, 1'b0);

        // Bounce train then steady hold: exactly one step, no auto-repeat
        @(negedge CLK); BTN[0] = 1'b1;
        @(negedge CLK); BTN[0] = 1'b0;
        @(negedge CLK); BTN[0] = 1'b1;
        @(negedge CLK); BTN[0] = 1'b0;
        @(negedge CLK); BTN[0] = 1'b1;
        e = edges;
        expect_step(e, 3, 0);
        repeat (30) @(negedge CLK);
        BTN[0] = 1'b0;
        repeat (12) @(negedge CLK);

        // Simultaneous rises cancel
        @(negedge CLK);
        e = edges;
        BTN = 2'b11;
        push_chk(e + 9, 0, mask, 1);
        push_chk(e + 15, 0, mask, 1);
        repeat (20) @(negedge CLK);
        BTN = 2'b00;
        repeat (12) @(negedge CLK);

        // Move to channel 2
        press(0, 10, 10, 0, 1, 1'b1);
        press(0, 10, 10, 1, 2, 1'b1);

        // Reset two counts into a debounce
        @(negedge CLK);
        BTN[0] = 1'b1;
        repeat (4) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("async_sel_hold", sel0, 0);
        chk("async_sel_zero", sel1, 0);
        chk("async_led_hold", led0, 0);
        chk("async_led_zero", led1, 0);
        chk("async_chg_hold", chg0, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        r = edges;
        mask = 1;
        expect_step(r, 0, 1);
        repeat (20) @(negedge CLK);
        BTN[0] = 1'b0;
        repeat (12) @(negedge CLK);

        repeat (5) @(negedge CLK);
        chk("chk_q_drained", chk_q.size(), 0);
        chk("chg_q_drained", chg_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
